// File: rtl/fixed_to_float.sv
// fixed_to_float: 32-bit two's-complement fixed-point to IEEE-754 single, one normalization bit per cycle
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready operand handshake (in_ready high only while idle)
//   fixed             two's-complement operand
//   fixpointpos       number of fractional bits in fixed (0..31)
//   out_valid/out_ready result handshake
//   result            IEEE-754 single {sign, exp[30:23], mantissa[22:0]}
// Define FIX2FLT_ROUND_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module fixed_to_float (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] fixed,
    input  logic [4:0]  fixpointpos,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
    state_t      state;
    logic        sign;
    logic [31:0] mag;
    logic [4:0]  fp;
    logic [5:0]  s;
    logic [7:0]  exp_c;
    logic [7:0]  exp_f;
    logic [23:0] man_r;
    assign in_ready = state == IDLE;
    // mag is normalized (bit 31 set) when this is consumed in ROUND
    always_comb begin
        exp_c = 8'd158 - {2'b0, s} - {3'b0, fp};
`ifdef FIX2FLT_ROUND_EN
        man_r = {1'b0, mag[30:8]} + {23'b0, mag[7] & ((|mag[6:0]) | mag[8])};
`else
        man_r = {1'b0, mag[30:8]};
`endif
        // a carry out of the mantissa leaves man_r[22:0] at zero and bumps the exponent
        exp_f = exp_c + {7'b0, man_r[23]};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sign      <= 1'b0;
            mag       <= 32'd0;
            fp        <= 5'd0;
            s         <= 6'd0;
            out_valid <= 1'b0;
            result    <= 32'd0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign  <= fixed[31];
                    mag   <= fixed[31] ? -fixed : fixed;
                    fp    <= fixpointpos;
                    s     <= 6'd0;
                    state <= NORM;
                end
                NORM: if (mag == 32'd0) begin
                    result    <= 32'd0;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end else if (mag[31]) begin
                    state <= ROUND;
                end else begin
                    mag <= mag << 1;
                    s   <= s + 6'd1;
                end
                ROUND: begin
                    result    <= {sign, exp_f, man_r[22:0]};
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_to_float.sv
// tb_fixed_to_float: randomized scoreboard bench for fixed_to_float against a real-arithmetic model
module tb_fixed_to_float;
    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] fixed = 0;
    logic [4:0]  fixpointpos = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [31:0] result;
    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;
    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rises = 0;
    bit          rand_ready = 0;
    bit          prev_v = 0;
    logic [31:0] held = 0;
    fixed_to_float dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fixed(fixed), .fixpointpos(fixpointpos), .out_valid(out_valid),
        .out_ready(out_ready), .result(result)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask
    // exact value as a real, then the IEEE single fields are read off its double encoding
    function automatic logic [31:0] ref_float(input logic [31:0] f, input int p);
        real         r;
        real         scale;
        logic [63:0] d;
        logic [10:0] e;
        logic [7:0]  ex;
        logic [23:0] man;
        if (f == 0) return 32'd0;
        scale = 1.0;
        for (int i = 0; i < p; i++) scale = scale * 2.0;
        r = $itor($signed(f)) / scale;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        ex = e[7:0];
        man = {1'b0, d[51:29]};
`ifdef FIX2FLT_ROUND_EN
        if (d[28] && ((|d[27:0]) || d[29])) man = man + 24'd1;
`endif
        if (man[23]) ex = ex + 8'd1;
        return {d[63], ex, man[22:0]};
    endfunction
    function automatic int ref_lat(input logic [31:0] f);
        logic [31:0] m;
        m = f[31] ? -f : f;
        if (m == 0) return 1;
        for (int i = 31; i >= 0; i--) if (m[i]) return 31 - i + 2;
        return 1;
    endfunction
    task automatic issue(input logic [31:0] f, input int p, input bit push);
        int   n;
        exp_t e;
        @(negedge clk);
        in_valid = 1;
        fixed = f;
        fixpointpos = 5'(p);
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready stuck low, expected high");
        end else if (push) begin
            e.res = ref_float(f, p);
            e.lat = ref_lat(f);
            e.acc = cyc + 1;
            q.push_back(e);
        end
        @(negedge clk);
        in_valid = 0;
        fixed = $urandom;
        fixpointpos = 5'($urandom);
    endtask
    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", q.size());
        end
    endtask
    initial forever begin
        @(negedge clk);
        if (rand_ready) out_ready = $urandom_range(0, 3) != 0;
    end
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (out_valid && !prev_v) begin
            rises++;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: out_valid=1 result=%h, expected no output", result);
            end else begin
                e = q.pop_front();
                check("result", result, e.res);
                check("latency", 32'(cyc - e.acc), 32'(e.lat));
                held = e.res;
            end
        end else if (out_valid) begin
            check("result_hold", result, held);
        end
        prev_v = out_valid;
    end
    initial begin
        int n;
        int r0;
        logic [31:0] f;
        repeat (2) @(negedge clk);
        rst = 0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", result, 32'd0);
        check("model_3p0", ref_float(32'h0000_0300, 8), 32'h4040_0000);
        rand_ready = 1;
        issue(32'h0000_0300, 8, 1);
        issue(32'hFFFF_FF00, 8, 1);
        issue(32'h0000_0000, 5, 1);
        issue(32'h8000_0000, 0, 1);
        issue(32'h7FFF_FFFF, 0, 1);
        issue(32'h0000_0001, 0, 1);
        issue(32'h0000_0001, 31, 1);
        issue(32'hFFFF_FFFF, 31, 1);
        issue(32'h00FF_FFFF, 3, 1);
        issue(32'h0000_0000, 31, 1);
        for (int i = 0; i < 150; i++) begin
            f = $urandom;
            case ($urandom_range(0, 2))
                0: f = f >> $urandom_range(0, 31);
                1: f = -(f >> $urandom_range(0, 31));
                default: ;
            endcase
            issue(f, $urandom_range(0, 31), 1);
        end
        drain();
        rand_ready = 0;
        out_ready = 0;
        issue(32'h0000_0300, 8, 1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1;
            fixed = $urandom;
            fixpointpos = 5'($urandom);
            @(negedge clk);
            check("bp_result", result, 32'h4040_0000);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 0;
        out_ready = 1;
        @(negedge clk);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        issue(32'h0000_0001, 0, 0);
        repeat (5) @(negedge clk);
        rst = 1;
        r0 = rises;
        @(negedge clk);
        rst = 0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        repeat (40) @(negedge clk);
        check("rst_no_output", 32'(rises), 32'(r0));
        rand_ready = 1;
        issue(32'hFFFF_FF00, 8, 1);
        issue(32'h7FFF_FFFF, 0, 1);
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
